// File: rtl/rx_dma_pkg.sv
// rx_dma_pkg: shared word/sample types and constants for the RX sample path.
package rx_dma_pkg;
  typedef logic [127:0] rx_word_t;
  typedef logic [31:0] rx_sample_t;
  localparam int RX_LANES = 4;
  localparam logic [7:0] RX_OVF_MAX = 8'd255;
endpackage

// File: rtl/rx_fifo_ram.sv
// rx_fifo_ram: simple dual-port registered-read RAM, kept separate so it maps onto block RAM.
module rx_fifo_ram
  import rx_dma_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic we,
  input  logic re,
  input  logic [AW-1:0] waddr,
  input  logic [AW-1:0] raddr,
  input  rx_word_t wdata,
  output rx_word_t rdata
);
  rx_word_t mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/rx_sample_burst_fifo.sv
// rx_sample_burst_fifo: packs 32-bit IQ samples into 128-bit words and buffers them as a FWFT stream.
// Optional macro RX_FILL_WATERMARK_EN adds fill_watermark and watermark_clear.
module rx_sample_burst_fifo
  import rx_dma_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic enable,
  input  logic flush,
  input  logic [8:0] burst_len,
  input  logic [31:0] s_axis_adc_tdata,
  input  logic s_axis_adc_tvalid,
  output logic [127:0] m_axis_rx_tdata,
  output logic m_axis_rx_tvalid,
  input  logic m_axis_rx_tready,
  output logic rx_fifo_data_ready,
  output logic [AW:0] fill_level,
  output logic overflow_flag,
  output logic [7:0] overflow_count
`ifdef RX_FILL_WATERMARK_EN
  ,
  input  logic watermark_clear,
  output logic [AW:0] fill_watermark
`endif
);
  logic [1:0] lane;
  logic [95:0] pack;
  rx_word_t push_word, q;
  logic push_v, qv, accept, pop, push_ok, load, rd_en;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] mem_cnt, fill_nxt;
  // fill_level counts memory, the RAM read register and the output register,
  // so the memory share falls out by subtraction; fill_level == DEPTH only when its MSB is set
  always_comb begin
    accept = enable && s_axis_adc_tvalid;
    pop = m_axis_rx_tvalid && m_axis_rx_tready;
    push_ok = push_v && !fill_level[AW];
    mem_cnt = fill_level - (AW+1)'(qv) - (AW+1)'(m_axis_rx_tvalid);
    load = qv && (!m_axis_rx_tvalid || pop);
    rd_en = (mem_cnt != '0) && (!qv || load);
    fill_nxt = fill_level + (AW+1)'(push_ok) - (AW+1)'(pop);
  end
  rx_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .clk(aclk), .we(push_ok), .re(rd_en), .waddr(wr_ptr), .raddr(rd_ptr),
    .wdata(push_word), .rdata(q)
  );
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lane <= '0; pack <= '0; push_word <= '0; push_v <= 1'b0;
      wr_ptr <= '0; rd_ptr <= '0; qv <= 1'b0;
      m_axis_rx_tdata <= '0; m_axis_rx_tvalid <= 1'b0; fill_level <= '0;
      rx_fifo_data_ready <= 1'b0; overflow_flag <= 1'b0; overflow_count <= '0;
    end else if (flush) begin
      lane <= '0; pack <= '0; push_word <= '0; push_v <= 1'b0;
      wr_ptr <= '0; rd_ptr <= '0; qv <= 1'b0;
      m_axis_rx_tdata <= '0; m_axis_rx_tvalid <= 1'b0; fill_level <= '0;
      rx_fifo_data_ready <= 1'b0; overflow_flag <= 1'b0; overflow_count <= '0;
    end else begin
      push_v <= accept && lane == 2'(RX_LANES - 1);
      if (accept) begin
        lane <= lane + 2'd1;
        if (lane == 2'(RX_LANES - 1)) push_word <= {s_axis_adc_tdata, pack};
        else pack[32*lane +: 32] <= s_axis_adc_tdata;
      end else if (!enable) lane <= '0;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (push_v && fill_level[AW]) begin
        overflow_flag <= 1'b1;
        if (overflow_count != RX_OVF_MAX) overflow_count <= overflow_count + 8'd1;
      end
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      qv <= rd_en ? 1'b1 : (load ? 1'b0 : qv);
      if (load) m_axis_rx_tdata <= q;
      m_axis_rx_tvalid <= load ? 1'b1 : (pop ? 1'b0 : m_axis_rx_tvalid);
      fill_level <= fill_nxt;
      rx_fifo_data_ready <= (fill_nxt >= (AW+1)'(burst_len)) && (burst_len != 9'd0);
    end
  end
`ifdef RX_FILL_WATERMARK_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) fill_watermark <= '0;
    else if (flush) fill_watermark <= '0;
    else if (watermark_clear) fill_watermark <= fill_level;
    else if (fill_level > fill_watermark) fill_watermark <= fill_level;
  end
`endif
endmodule

// File: tb/tb_rx_sample_burst_fifo.sv
// tb_rx_sample_burst_fifo: directed stimulus checked each cycle against a queue-based FIFO model.
`timescale 1ns/1ps
module tb_rx_sample_burst_fifo;
  localparam int DEPTH = 256;
  localparam int AW = 8;
  logic aclk = 1'b0, aresetn = 1'b0, enable = 1'b0, flush = 1'b0;
  logic [8:0] burst_len = 9'd16;
  logic [31:0] s_data = '0;
  logic s_valid = 1'b0;
  logic [127:0] m_data;
  logic m_valid, rdy, ovf_flag;
  logic m_ready = 1'b0;
  logic [AW:0] fill;
  logic [7:0] ovf_cnt;
  logic [31:0] sv = 32'h100;
  int pass = 0, total = 0;
`ifdef RX_FILL_WATERMARK_EN
  logic wm_clear = 1'b0;
  logic [AW:0] wm;
`endif

  always #5 aclk = ~aclk;

  rx_sample_burst_fifo #(.DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .flush(flush), .burst_len(burst_len),
    .s_axis_adc_tdata(s_data), .s_axis_adc_tvalid(s_valid),
    .m_axis_rx_tdata(m_data), .m_axis_rx_tvalid(m_valid), .m_axis_rx_tready(m_ready),
    .rx_fifo_data_ready(rdy), .fill_level(fill), .overflow_flag(ovf_flag), .overflow_count(ovf_cnt)
`ifdef RX_FILL_WATERMARK_EN
    , .watermark_clear(wm_clear), .fill_watermark(wm)
`endif
  );

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %h want %h", n, a, e);
  endtask

  // Model: a word queue where each word becomes visible two edges after it lands
  typedef struct { logic [127:0] d; int avail; } ent_t;
  ent_t fq[$];
  int cyc = 0, lane_m = 0, ovf_m = 0, wm_m = 0;
  logic [31:0] part [4];
  bit pend_m = 0, flag_m = 0, rdy_m = 0;
  logic [127:0] pend_w;

  always @(posedge aclk) begin
    int sz;
    bit shown;
    ent_t e;
    sz = fq.size();
    shown = sz > 0 && fq[0].avail <= cyc;
    cyc++;
    if (!aresetn || flush) begin
      fq.delete(); lane_m = 0; pend_m = 0; ovf_m = 0; flag_m = 0; rdy_m = 0; wm_m = 0;
    end else begin
`ifdef RX_FILL_WATERMARK_EN
      wm_m = wm_clear ? sz : (sz > wm_m ? sz : wm_m);
`endif
      if (shown && m_ready) fq.delete(0);
      if (pend_m) begin
        if (sz < DEPTH) begin e.d = pend_w; e.avail = cyc + 2; fq.push_back(e); end
        else begin flag_m = 1; if (ovf_m < 255) ovf_m++; end
      end
      pend_m = 0;
      if (enable && s_valid) begin
        part[lane_m] = s_data;
        if (lane_m == 3) begin
          pend_m = 1; pend_w = {part[3], part[2], part[1], part[0]}; lane_m = 0;
        end else lane_m++;
      end else if (!enable) lane_m = 0;
      rdy_m = fq.size() >= int'(burst_len) && burst_len != 0;
    end
  end

  always @(negedge aclk) if (aresetn) begin
    bit v;
    v = fq.size() > 0 && fq[0].avail <= cyc;
    chk("tvalid", m_valid, v);
    if (v) chk("tdata", m_data, fq[0].d);
    chk("fill_level", fill, fq.size());
    chk("data_ready", rdy, rdy_m);
    chk("ovf_flag", ovf_flag, flag_m);
    chk("ovf_count", ovf_cnt, ovf_m);
`ifdef RX_FILL_WATERMARK_EN
    chk("watermark", wm, wm_m);
`endif
  end

  task automatic send(input logic [31:0] v);
    s_valid = 1'b1; s_data = v;
    @(negedge aclk);
    s_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge aclk);
    flush = 1'b0;
  endtask

  initial begin
    int cnt, maxf;
    logic [31:0] b;
    repeat (3) @(negedge aclk);
    chk("rst_tvalid", m_valid, 0); chk("rst_tdata", m_data, 0); chk("rst_fill", fill, 0);
    chk("rst_ready", rdy, 0); chk("rst_flag", ovf_flag, 0); chk("rst_count", ovf_cnt, 0);
    #2 aresetn = 1'b1;
    @(negedge aclk);
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) send(i);
    repeat (4) @(negedge aclk);
    chk("t1_tvalid", m_valid, 1);
    chk("t1_word", m_data, 128'h00000004_00000003_00000002_00000001);
    chk("t1_fill", fill, 1);
    m_ready = 1'b1; @(negedge aclk); m_ready = 1'b0;
    chk("t1_popped", fill, 0);

    do_flush();
    for (int i = 0; i < 64; i++) begin send(sv); sv++; end
    repeat (4) @(negedge aclk);
    chk("t2_ready", rdy, 1); chk("t2_fill", fill, 16); chk("t2_ovf", ovf_cnt, 0);
    burst_len = 9'd17; @(negedge aclk);
    chk("t2_len17", rdy, 0);
    burst_len = 9'd0; @(negedge aclk);
    chk("t2_len0", rdy, 0);
    burst_len = 9'd16; @(negedge aclk);
    chk("t2_len16", rdy, 1);

    do_flush();
    b = sv;
    for (int i = 0; i < 1040; i++) begin send(sv); sv++; end
    repeat (5) @(negedge aclk);
    chk("t3_fill", fill, 256); chk("t3_flag", ovf_flag, 1); chk("t3_count", ovf_cnt, 4);
    chk("t3_first", m_data, {b + 32'd3, b + 32'd2, b + 32'd1, b});
    m_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 256; i++) begin if (m_valid) cnt++; @(negedge aclk); end
    chk("t3_nogaps", cnt, 256); chk("t3_empty", m_valid, 0); chk("t3_fill0", fill, 0);

    do_flush();
    maxf = 0;
    for (int i = 0; i < 10000; i++) begin
      send(sv); sv++;
      if (int'(fill) > maxf) maxf = int'(fill);
    end
    repeat (6) @(negedge aclk);
    chk("t4_maxfill_le3", maxf <= 3, 1); chk("t4_noovf", ovf_flag, 0); chk("t4_drained", fill, 0);

    do_flush();
    m_ready = 1'b0;
    send(32'hAAAA0001); send(32'hAAAA0002);
    enable = 1'b0; @(negedge aclk); enable = 1'b1;
    for (int i = 1; i <= 4; i++) send(32'hBBBB0000 + i);
    repeat (4) @(negedge aclk);
    chk("t5_word", m_data, 128'hBBBB0004_BBBB0003_BBBB0002_BBBB0001);
    chk("t5_fill", fill, 1);

    do_flush();
    for (int i = 0; i < 400; i++) begin send(sv); sv++; end
    repeat (4) @(negedge aclk);
    chk("t6_fill100", fill, 100);
    #2 aresetn = 1'b0;
    #1;
    chk("t6_tvalid", m_valid, 0); chk("t6_tdata", m_data, 0); chk("t6_fill", fill, 0);
    chk("t6_ready", rdy, 0); chk("t6_flag", ovf_flag, 0); chk("t6_count", ovf_cnt, 0);
    @(negedge aclk);
    #2 aresetn = 1'b1;
    @(negedge aclk);
    for (int i = 1; i <= 4; i++) send(32'hC0DE0000 + i);
    repeat (4) @(negedge aclk);
    chk("t6_word", m_data, 128'hC0DE0004_C0DE0003_C0DE0002_C0DE0001);
    chk("t6_fill1", fill, 1);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
